// File: rtl/md_pkg.sv
// Shared types and constants for the 3x3 determinant front end.
// Row layout: [15:0]=col0, [31:16]=col1, [47:32]=col2.
package md_pkg;

    localparam int ELEM_W        = 16;
    localparam int ROW_W         = 48;
    localparam int ELEMS_PER_MAT = 9;
    localparam int LAST_IDX      = 8;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT_LOW
    } feeder_state_e;

    function automatic logic [ELEM_W-1:0] col_sel(
        input logic [ROW_W-1:0] row,
        input logic [1:0]       c
    );
        unique case (1'b1)
            c == 2'd1: col_sel = row[31:16];
            c == 2'd2: col_sel = row[47:32];
            default:   col_sel = row[15:0];
        endcase
    endfunction

endpackage

// File: rtl/matrix_row_feeder_row_fifo.sv
// Row FIFO with head and head+1 read ports.
// Pointers wrap at DEPTH; a push is refused whenever the FIFO is full.
module row_fifo
    import md_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [ROW_W-1:0] data_i,
    input  logic             pop_i,
    output logic [ROW_W-1:0] head_o,
    output logic [ROW_W-1:0] next_o,
    output logic [LW-1:0]    level_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ROW_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [LW-1:0]    level_q;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rptr_q];
    assign next_o  = mem_q[inc(rptr_q)];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= inc(wptr_q);
            end
            if (pop_ok) rptr_q <= inc(rptr_q);
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/matrix_row_feeder.sv
// Serialises buffered 3-row matrices into a gap-free stream of nine
// elements for the determinant unit, paced by mat_request.
module matrix_row_feeder
    import md_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROW_W-1:0]  row_data,
    input  logic              row_valid,
    output logic              row_ready,
    output logic [ELEM_W-1:0] mat_in,
    output logic              mat_valid,
    input  logic              mat_request,
    output logic [LW-1:0]     fifo_level,
    output logic [15:0]       mat_count,
    output logic              proto_err
);

    feeder_state_e     state_q;
    logic [3:0]        idx_q;
    logic [1:0]        col_q;
    logic [ELEM_W-1:0] mat_in_q;
    logic              mat_valid_q;
    logic [15:0]       mat_count_q;
    logic              proto_err_q;

    logic [ROW_W-1:0]  head_row;
    logic [ROW_W-1:0]  next_row;
    logic [LW-1:0]     level;
    logic              full;
    logic              empty;
    logic              pop;
    logic              last;
    logic              start;
    logic [1:0]        col_nxt;
    logic [ELEM_W-1:0] elem_nxt;

    row_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (row_valid),
        .data_i  (row_data),
        .pop_i   (pop),
        .head_o  (head_row),
        .next_o  (next_row),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    assign row_ready  = !full;
    assign fifo_level = level;
    assign mat_in     = mat_in_q;
    assign mat_valid  = mat_valid_q;
    assign mat_count  = mat_count_q;
    assign proto_err  = proto_err_q;

    assign last    = (idx_q == 4'(LAST_IDX));
    assign start   = (level >= LW'(3)) && mat_request;
    assign pop     = (state_q == STREAM) && (col_q == 2'd2);
    assign col_nxt = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
    // After col2 the head is being popped, so the next element comes from head+1.
    assign elem_nxt = col_sel((col_q == 2'd2) ? next_row : head_row, col_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            col_q       <= '0;
            mat_in_q    <= '0;
            mat_valid_q <= 1'b0;
            mat_count_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= STREAM;
                        mat_in_q    <= col_sel(head_row, 2'd0);
                        mat_valid_q <= 1'b1;
                        idx_q       <= '0;
                        col_q       <= '0;
                    end
                end
                STREAM: begin
                    if (!mat_request && !last) proto_err_q <= 1'b1;
                    if (!last) begin
                        idx_q    <= idx_q + 4'd1;
                        col_q    <= col_nxt;
                        mat_in_q <= elem_nxt;
                    end else begin
                        mat_valid_q <= 1'b0;
                        mat_count_q <= mat_count_q + 16'd1;
                        idx_q       <= '0;
                        col_q       <= '0;
                        state_q     <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (!mat_request) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
